// File: rtl/regarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regarb_pkg
//  Description : Shared definitions for the register-file write arbiter.
//                Holds the default address/data widths, the register count
//                of the target register file, and the round-robin one-hot
//                pick function used by rr_picker.
//  Revision    : 1.0  initial release
// ============================================================================
package regarb_pkg;

    localparam int unsigned SIZE_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT   = 32;
    localparam int unsigned REG_COUNT    = 32;

    // Upper bound on requester count; the pick function works on a vector
    // of this width and callers zero-extend their eligibility mask into it.
    localparam int unsigned MAX_REQ      = 8;
    localparam int unsigned MAX_PW       = $clog2(MAX_REQ);

    // Search 'eligible' starting at index 'ptr' upward, wrapping at 'nreq',
    // and return a one-hot vector marking the first hit (all zero if none).
    function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
        input logic [MAX_REQ-1:0] eligible,
        input int unsigned        ptr,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] onehot;
        logic               found;
        int unsigned        pos;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = ptr + k;
            if (pos >= nreq) begin
                pos = pos - nreq;
            end
            if ((k < nreq) && !found && eligible[pos[MAX_PW-1:0]]) begin
                onehot[pos[MAX_PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Finds the first set bit
//                of 'eligible' at or above 'ptr' (with wrap) and reports its
//                index.
//  Ports       : eligible  in  NREQ            candidate mask
//                ptr       in  clog2(NREQ)     highest-priority index
//                valid     out 1               any bit eligible
//                g         out clog2(NREQ)     index of the selected bit
//  Revision    : 1.0  initial release
// ============================================================================
module rr_picker
    import regarb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] g
);

    localparam int PW = $clog2(NREQ);

    logic [MAX_REQ-1:0] elig_ext;
    logic [MAX_REQ-1:0] pick_oh;

    always_comb begin
        elig_ext             = '0;
        elig_ext[NREQ-1:0]   = eligible;
    end

    assign pick_oh = rr_pick_onehot(elig_ext, 32'(ptr), NREQ);

    // Bits above NREQ are never set by the pick, so a plain OR is enough.
    always_comb begin
        valid = |pick_oh;
        g     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                g = i[PW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Round-robin arbiter sharing the single write port of a
//                32 x 32-bit register file among NREQ requesters. The chosen
//                write is registered for one cycle so the register file sees
//                clean write controls, and a one-cycle ack is returned to the
//                granted requester.
//  Ports       : clk        in   1          clock
//                Reset      in   1          async active-high reset
//                req        in   NREQ       level write requests
//                req_addr   in   NREQ*SIZE  packed addresses
//                req_data   in   NREQ*DW    packed data
//                ack        out  NREQ       one-hot grant pulse
//                Write_Reg  out  1          register file write enable
//                W_Addr     out  SIZE       register file write address
//                W_Data     out  DW         register file write data
//                busy       out  1          any request or write in flight
//  Build macro : REGARB_R0_PROTECT_EN - when defined, a granted write to
//                address 0 is acked but Write_Reg stays low, so register 0
//                keeps its reset value.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SIZE = SIZE_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 Write_Reg,
    output logic [SIZE-1:0]      W_Addr,
    output logic [DW-1:0]        W_Data,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [NREQ-1:0] ack_q,   ack_d;
    logic            wr_q,    wr_d;
    logic [SIZE-1:0] waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    logic [PW-1:0]   pick_g;
    logic [SIZE-1:0] sel_addr;
    logic [DW-1:0]   sel_data;

    // The requester being acked this cycle still has req high; masking it
    // keeps the same request from being granted twice.
    assign eligible = req & ~ack_q;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .valid    (pick_valid),
        .g        (pick_g)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_g == i[PW-1:0]) begin
                sel_addr = req_addr[i*SIZE +: SIZE];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        ack_d   = '0;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pick_valid) begin
            ack_d[pick_g] = 1'b1;
            waddr_d       = sel_addr;
            wdata_d       = sel_data;
`ifdef REGARB_R0_PROTECT_EN
            wr_d          = (sel_addr != '0);
`else
            wr_d          = 1'b1;
`endif
            if (pick_g == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_g + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ptr_q   <= '0;
            ack_q   <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack       = ack_q;
    assign Write_Reg = wr_q;
    assign W_Addr    = waddr_q;
    assign W_Data    = wdata_q;
    assign busy      = (|req) | wr_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Self-checking bench for regfile_wr_arbiter (NREQ=4). The
//                stimulus pushes the expected write (cycle, ack, enable,
//                address, data) into a queue; a monitor pops and compares
//                whenever the DUT shows ack or Write_Reg. A register file
//                model captures the DUT writes for read-back checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int SIZE = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic [31:0]     cyc;
        logic [NREQ-1:0] ack;
        logic            wr;
        logic [SIZE-1:0] addr;
        logic [DW-1:0]   data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 Reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic                 Write_Reg;
    logic [SIZE-1:0]      W_Addr;
    logic [DW-1:0]        W_Data;
    logic                 busy;

    logic [31:0] cyc = '0;
    logic [31:0] rf [32] = '{default: '0};
    logic [NREQ-1:0] hold;
    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int total = 0;
    int bad   = 0;

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .SIZE (SIZE),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .Write_Reg (Write_Reg),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (Write_Reg) rf[W_Addr] <= W_Data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input int off, input logic [NREQ-1:0] a, input logic w,
                        input logic [SIZE-1:0] ad, input logic [DW-1:0] d);
        exp_q.push_back('{cyc + 32'(off), a, w, ad, d});
    endtask

    task automatic set_rq(input int i, input logic [SIZE-1:0] a, input logic [DW-1:0] d);
        req_addr[i*SIZE +: SIZE] = a;
        req_data[i*DW +: DW]     = d;
    endtask

    // Advance one cycle; requesters that saw their ack drop req unless held.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && !hold[i]) req[i] = 1'b0;
        end
    endtask

    initial begin
        Reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        hold     = '0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!Reset && ((|ack) || Write_Reg)) begin
                        mon_act = '{cyc, ack, Write_Reg, W_Addr, W_Data};
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL sb_unexpected: got cyc=%0d ack=%b wr=%b addr=%0d data=%h, required no write",
                                     mon_act.cyc, mon_act.ack, mon_act.wr, mon_act.addr, mon_act.data);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            if (mon_act !== mon_exp) begin
                                bad++;
                                $display("FAIL sb_write: got cyc=%0d ack=%b wr=%b addr=%0d data=%h, required cyc=%0d ack=%b wr=%b addr=%0d data=%h",
                                         mon_act.cyc, mon_act.ack, mon_act.wr, mon_act.addr, mon_act.data,
                                         mon_exp.cyc, mon_exp.ack, mon_exp.wr, mon_exp.addr, mon_exp.data);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                // Reset state
                #2 Reset = 1'b1;
                step();
                step();
                chk("rst_ack",   64'(ack),       64'(0));
                chk("rst_wr",    64'(Write_Reg), 64'(0));
                chk("rst_waddr", 64'(W_Addr),    64'(0));
                chk("rst_wdata", 64'(W_Data),    64'(0));
                chk("rst_busy0", 64'(busy),      64'(0));
                req = 4'b0001;
                #1 chk("busy_comb", 64'(busy), 64'(1));
                req = '0;
                step();
                Reset = 1'b0;

                // Single request, no competition
                set_rq(2, 5'd5, 32'h1234_5678);
                req[2] = 1'b1;
                push(1, 4'b0100, 1'b1, 5'd5, 32'h1234_5678);
                step();
                chk("busy_wr_only", 64'(busy), 64'(1));
                step();
                chk("rf5_read", 64'(rf[5]), 64'h1234_5678);
                chk("idle_wr",   64'(Write_Reg), 64'(0));
                chk("idle_busy", 64'(busy),      64'(0));

                // All four together after reset: grants 0,1,2,3 back to back
                Reset = 1'b1;
                #1;
                chk("rst2_ack", 64'(ack), 64'(0));
                step();
                Reset = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    set_rq(i, 5'(8 + i), 32'(i) * 32'h1111_1111);
                    push(i + 1, 4'(1 << i), 1'b1, 5'(8 + i), 32'(i) * 32'h1111_1111);
                end
                req = 4'b1111;
                repeat (4) step();
                step();
                chk("all4_done_ack", 64'(ack),       64'(0));
                chk("all4_done_wr",  64'(Write_Reg), 64'(0));
                chk("rf11_read",     64'(rf[11]),    64'h3333_3333);

                // Move ptr to 2, then req 0011 -> 0 then 1; then 1001 -> 3 then 0
                set_rq(0, 5'd16, 32'hA0A0_A0A0);
                set_rq(1, 5'd17, 32'hB1B1_B1B1);
                set_rq(3, 5'd19, 32'hD3D3_D3D3);
                req = 4'b0010;
                push(1, 4'b0010, 1'b1, 5'd17, 32'hB1B1_B1B1);
                step();
                step();
                req = 4'b0011;
                push(1, 4'b0001, 1'b1, 5'd16, 32'hA0A0_A0A0);
                push(2, 4'b0010, 1'b1, 5'd17, 32'hB1B1_B1B1);
                step();
                step();
                req = 4'b1001;
                push(1, 4'b1000, 1'b1, 5'd19, 32'hD3D3_D3D3);
                push(2, 4'b0001, 1'b1, 5'd16, 32'hA0A0_A0A0);
                step();
                step();
                step();

                // Requester 1 holds req: ack every other cycle
                hold[1] = 1'b1;
                set_rq(1, 5'd20, 32'hCAFE_0001);
                req = 4'b0010;
                push(1, 4'b0010, 1'b1, 5'd20, 32'hCAFE_0001);
                push(3, 4'b0010, 1'b1, 5'd20, 32'hCAFE_0001);
                push(5, 4'b0010, 1'b1, 5'd20, 32'hCAFE_0001);
                repeat (6) step();
                req  = '0;
                hold = '0;
                step();

                // Reset while ack[0] is high; re-arbitrated one cycle after release
                hold[0] = 1'b1;
                set_rq(0, 5'd21, 32'h5A5A_5A5A);
                req = 4'b0001;
                step();
                chk("pre_rst_ack0", 64'(ack), 64'(4'b0001));
                #1 Reset = 1'b1;
                #1;
                chk("mid_rst_ack", 64'(ack),       64'(0));
                chk("mid_rst_wr",  64'(Write_Reg), 64'(0));
                #1 Reset = 1'b0;
                push(1, 4'b0001, 1'b1, 5'd21, 32'h5A5A_5A5A);
                hold[0] = 1'b0;
                step();
                step();

                // Address 0 write
                set_rq(1, 5'd0, 32'hFFFF_FFFF);
                req = 4'b0010;
`ifdef REGARB_R0_PROTECT_EN
                push(1, 4'b0010, 1'b0, 5'd0, 32'hFFFF_FFFF);
`else
                push(1, 4'b0010, 1'b1, 5'd0, 32'hFFFF_FFFF);
`endif
                step();
                step();
`ifdef REGARB_R0_PROTECT_EN
                chk("rf0_read", 64'(rf[0]), 64'(0));
`else
                chk("rf0_read", 64'(rf[0]), 64'hFFFF_FFFF);
`endif
                step();
                step();
                chk("sb_drain", 64'(exp_q.size()), 64'(0));

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter that shares the single write port of the 32 x 32-bit two-read/one-write register file among NREQ independent requesters. It sits between the requesters and the register file's Write_Reg / W_Addr / W_Data inputs. It registers the selected write for one cycle, so the register file sees clean, glitch-free write controls. It returns a one-cycle acknowledge to the requester whose write was issued.

## Interface
- NREQ, 4, number of requesters (2..8)
- SIZE, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write request, level, held until ack
- req_addr  in  NREQ*SIZE  packed addresses, requester i at [i*SIZE +: SIZE]
- req_data  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- ack  out  NREQ  one-hot, one-cycle pulse: requester's write is on the port this cycle
- Write_Reg  out  1  write enable to register file
- W_Addr  out  SIZE  write address to register file
- W_Data  out  DW  write data to register file
- busy  out  1  high when any req bit is high or Write_Reg is high

## Operation
- Requester i asserts req[i] with req_addr/req_data stable, and keeps them stable until it samples ack[i]=1.
- eligible = req & ~ack. The bit currently acked is never re-selected in the same cycle.
- Round-robin pointer ptr (clog2(NREQ) bits) is the highest-priority index. Search eligible from ptr upward with wrap, and take the first hit g.
- If any bit is eligible, the next edge loads Write_Reg=1, W_Addr=req_addr[g], W_Data=req_data[g], ack=one-hot(g), ptr=(g+1) mod NREQ.
- If no bit is eligible, the next edge loads Write_Reg=0, ack=0, and W_Addr/W_Data hold their values. ptr holds.
- There is no state machine beyond the output register and ptr. The block issues one write per cycle at full throughput.
- Requesters drop or change req in the cycle after ack. A requester that keeps req high after ack is treated as a new request.

## Timing
- Reset (async) clears: ack=0, Write_Reg=0, W_Addr=0, W_Data=0, ptr=0. busy then follows req combinationally.
- Latency from req rising (cycle N) to ack/Write_Reg high is cycle N+1, when no competitor has priority. The register file captures the write at the end of N+1.
- With all NREQ requesters asserted together, grants follow ptr order, one per cycle. Worst-case wait is NREQ cycles.
- Reset during a pending ack: ack and Write_Reg drop immediately and that write is lost. A req still held after Reset deasserts is re-arbitrated from ptr=0.
- Simultaneous req rise and ack of a different requester: no interaction. Eligibility is evaluated per bit.

## Configuration
- REGARB_R0_PROTECT_EN defined: a selected write with address 0 is acked normally, but Write_Reg stays 0 for that cycle, so register 0 stays constant (zero after reset). W_Addr/W_Data still load.
- Not defined: address 0 is written like any other address.

## Structure
- Shared package regarb_pkg: SIZE and DW defaults, REG_COUNT=32, and a function for the round-robin one-hot pick.
- One sub-module, rr_picker: combinational; inputs eligible and ptr; outputs valid and index g. It is instantiated once, and regfile_wr_arbiter holds all registers.

## Test plan
- Single req[2]=1, addr=5, data=32'h1234_5678 at cycle 0 -> cycle 1: ack=4'b0100, Write_Reg=1, W_Addr=5; the register file reads 32'h1234_5678 at address 5 in cycle 2. ptr=3.
- After Reset, req=4'b1111 with data i*32'h1111_1111, dropped after ack -> acks 0,1,2,3 on cycles 1..4; Write_Reg high for exactly 4 cycles.
- ptr=2, req=4'b0011 -> ack 0 then ack 1. Then req[3] and req[0] together -> ack[3] first.
- Requester 1 holds req[1] continuously, others idle -> ack[1] pulses every other cycle, never on two consecutive cycles.
- Reset asserted mid-cycle while ack[0]=1 -> ack and Write_Reg go 0 immediately. After release with req[0] still high, ack[0] appears one cycle later.
- REGARB_R0_PROTECT_EN: req[1], addr=0, data=32'hFFFF_FFFF -> ack[1]=1, Write_Reg=0, register 0 reads 0. Without the macro, register 0 reads 32'hFFFF_FFFF.
